// File: rtl/vram_stream.sv
// Dual-access video RAM: pipelined byte-lane CPU port plus a streaming read port
// that feeds a 2-entry output buffer under valid/ready flow control.
//
// state  | meaning
// IDLE   | waiting for vid_start
// RUN    | fetching words into the buffer and presenting them to the sink
// DONE   | one-cycle vid_done pulse, then back to IDLE
module vram_stream #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int BYTES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [BYTES-1:0]  cpu_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              vid_start,
  input  logic [ADDR_W-1:0] vid_base,
  input  logic [ADDR_W:0]   vid_len,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              vid_ready,
  output logic              vid_busy,
  output logic              vid_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] buf_q [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W:0]   fetch_left, xfer_left;
  logic              fetch, pop;

  // Storage has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (cpu_req && cpu_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (cpu_be[i]) mem[cpu_addr][8*i +: 8] <= cpu_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
    end else begin
      cpu_ack <= cpu_req;
      if (cpu_req && !cpu_we) cpu_dout <= mem[cpu_addr];
    end
  end

  assign vid_valid = (count != 2'd0);
  assign vid_data  = buf_q[rd_ptr];
  assign pop       = vid_valid && vid_ready;
  // A full buffer may still fetch when a word leaves in the same cycle.
  assign fetch     = (state_q == S_RUN) && (fetch_left != '0) && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      fetch_addr <= '0;
      fetch_left <= '0;
      xfer_left  <= '0;
    end else if (state_q == S_IDLE && vid_start) begin
      fetch_addr <= vid_base;
      fetch_left <= vid_len;
      xfer_left  <= vid_len;
    end else begin
      if (fetch) begin
        buf_q[wr_ptr] <= mem[fetch_addr];
        wr_ptr        <= ~wr_ptr;
        fetch_addr    <= fetch_addr + 1'b1;
        fetch_left    <= fetch_left - 1'b1;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        xfer_left <= xfer_left - 1'b1;
      end
      count <= count + {1'b0, fetch} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    vid_busy = 1'b0;
    vid_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vid_start) state_d = (vid_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        vid_busy = 1'b1;
        if (pop && xfer_left == (ADDR_W+1)'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        vid_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
